cache_mem_arbiter: RTL and testbench

- Arbitrates the single word-wide memory port between two cache controllers: requester 0 is the instruction cache and requester 1 is the data cache.
- Each grant moves one whole line as a burst of 2**WORD_OFFSET single-word memory transactions, using the cache4way memory handshake (mem_req_o held high, mem_ack_i pulsed for one cycle).
- Sits between the cache miss/MSHR logic and external memory. Selection is round-robin with burst-granular fairness.

---
 rtl/cache_mem_arbiter_if.sv | 50 +++++
 rtl/cache_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the two cache-side line-transfer ports and the single word-wide memory port.
// The arbiter takes the master modport; the caches and memory together drive the slave side.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORD_OFFSET = 2
);
  logic                   c0_req_i;
  logic [ADR_WIDTH-1:0]   c0_adr_i;
  logic                   c0_rdwr_i;
  logic [DATA_WIDTH-1:0]  c0_dat_i;
  logic [WORD_OFFSET-1:0] c0_word_o;
  logic                   c0_ack_o;
  logic [DATA_WIDTH-1:0]  c0_dat_o;
  logic                   c0_done_o;

  logic                   c1_req_i;
  logic [ADR_WIDTH-1:0]   c1_adr_i;
  logic                   c1_rdwr_i;
  logic [DATA_WIDTH-1:0]  c1_dat_i;
  logic [WORD_OFFSET-1:0] c1_word_o;
  logic                   c1_ack_o;
  logic [DATA_WIDTH-1:0]  c1_dat_o;
  logic                   c1_done_o;

  logic                   mem_req_o;
  logic [ADR_WIDTH-1:0]   mem_adr_o;
  logic                   mem_rdwr_o;
  logic [DATA_WIDTH-1:0]  mem_dat_o;
  logic                   mem_ack_i;
  logic [DATA_WIDTH-1:0]  mem_dat_i;

  modport master (
    input  c0_req_i, c0_adr_i, c0_rdwr_i, c0_dat_i,
    output c0_word_o, c0_ack_o, c0_dat_o, c0_done_o,
    input  c1_req_i, c1_adr_i, c1_rdwr_i, c1_dat_i,
    output c1_word_o, c1_ack_o, c1_dat_o, c1_done_o,
    output mem_req_o, mem_adr_o, mem_rdwr_o, mem_dat_o,
    input  mem_ack_i, mem_dat_i
  );

  modport slave (
    output c0_req_i, c0_adr_i, c0_rdwr_i, c0_dat_i,
    input  c0_word_o, c0_ack_o, c0_dat_o, c0_done_o,
    output c1_req_i, c1_adr_i, c1_rdwr_i, c1_dat_i,
    input  c1_word_o, c1_ack_o, c1_dat_o, c1_done_o,
    input  mem_req_o, mem_adr_o, mem_rdwr_o, mem_dat_o,
    output mem_ack_i, mem_dat_i
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter granting the memory port to the I-cache (c0) or D-cache (c1) for a
// whole-line burst of single-word req/ack transactions.
module cache_mem_arbiter #(
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORD_OFFSET = 2
) (
  input logic                 clk,
  input logic                 rst,
  cache_mem_arbiter_if.master bus
);
  localparam int unsigned BaseWidth = ADR_WIDTH - WORD_OFFSET - 2;

  typedef enum logic [1:0] {StIdle, StXfer, StGap, StDone} state_e;

  state_e                 state_q, state_d;
  logic [WORD_OFFSET-1:0] word_cnt_q, word_cnt_d;
  logic [BaseWidth-1:0]   base_q, base_d;
  logic                   rdwr_q, rdwr_d;
  logic                   gnt_q, gnt_d;
  logic                   last_q, last_d;
  logic [DATA_WIDTH-1:0]  dat0_q, dat0_d;
  logic [DATA_WIDTH-1:0]  dat1_q, dat1_d;

  logic                   any_req;
  logic                   pick;

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_req = bus.c0_req_i | bus.c1_req_i;
    if (bus.c0_req_i && bus.c1_req_i) begin
      pick = ~last_q;
    end else begin
      pick = bus.c1_req_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      base_q     <= '0;
      rdwr_q     <= 1'b0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      dat0_q     <= '0;
      dat1_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      base_q     <= base_d;
      rdwr_q     <= rdwr_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      dat0_q     <= dat0_d;
      dat1_q     <= dat1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    base_d     = base_q;
    rdwr_d     = rdwr_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    dat0_d     = dat0_q;
    dat1_d     = dat1_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d      = pick;
          last_d     = pick;
          rdwr_d     = pick ? bus.c1_rdwr_i : bus.c0_rdwr_i;
          base_d     = pick ? bus.c1_adr_i[ADR_WIDTH-1 -: BaseWidth]
                            : bus.c0_adr_i[ADR_WIDTH-1 -: BaseWidth];
          word_cnt_d = '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (bus.mem_ack_i) begin
          if (gnt_q) begin
            dat1_d = bus.mem_dat_i;
          end else begin
            dat0_d = bus.mem_dat_i;
          end
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = (word_cnt_q == '1) ? StDone : StGap;
        end
      end
      StGap:   state_d = StXfer;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Gap and done cycles keep mem_req_o low so each one-cycle ack is consumed exactly once.
  always_comb begin
    bus.mem_req_o  = 1'b0;
    bus.mem_adr_o  = '0;
    bus.mem_rdwr_o = 1'b0;
    bus.mem_dat_o  = '0;
    bus.c0_word_o  = '0;
    bus.c1_word_o  = '0;
    bus.c0_ack_o   = 1'b0;
    bus.c1_ack_o   = 1'b0;
    bus.c0_done_o  = 1'b0;
    bus.c1_done_o  = 1'b0;
    unique case (state_q)
      StXfer: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_adr_o  = {base_q, word_cnt_q, 2'b00};
        bus.mem_rdwr_o = rdwr_q;
        bus.mem_dat_o  = gnt_q ? bus.c1_dat_i : bus.c0_dat_i;
        if (gnt_q) begin
          bus.c1_word_o = word_cnt_q;
        end else begin
          bus.c0_word_o = word_cnt_q;
        end
      end
      StGap: begin
        bus.c0_ack_o = ~gnt_q;
        bus.c1_ack_o = gnt_q;
      end
      StDone: begin
        bus.c0_ack_o  = ~gnt_q;
        bus.c1_ack_o  = gnt_q;
        bus.c0_done_o = ~gnt_q;
        bus.c1_done_o = gnt_q;
      end
      default: ;
    endcase
  end

  assign bus.c0_dat_o = dat0_q;
  assign bus.c1_dat_o = dat1_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized bursts against a line-level model of the arbiter: expected
// addresses, data, pulses and grant order follow from the line address and round-robin rule.
module tb_cache_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned WO = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   last_served = 1;

  cache_mem_arbiter_if #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(WO)) bus ();

  cache_mem_arbiter #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(WO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Write-back data source: each cache returns a tag plus the word index it is asked for.
  assign bus.c0_dat_i = 32'hB000_0000 + {{(DW-WO){1'b0}}, bus.c0_word_o};
  assign bus.c1_dat_i = 32'hA000_0000 + {{(DW-WO){1'b0}}, bus.c1_word_o};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(input int i);
    return (i == 0) ? bus.c0_ack_o : bus.c1_ack_o;
  endfunction

  function automatic logic get_done(input int i);
    return (i == 0) ? bus.c0_done_o : bus.c1_done_o;
  endfunction

  function automatic logic [WO-1:0] get_word(input int i);
    return (i == 0) ? bus.c0_word_o : bus.c1_word_o;
  endfunction

  function automatic logic [DW-1:0] get_dat(input int i);
    return (i == 0) ? bus.c0_dat_o : bus.c1_dat_o;
  endfunction

  task automatic set_req(input int i, input logic v);
    if (i == 0) bus.c0_req_i = v;
    else        bus.c1_req_i = v;
  endtask

  task automatic setup(input int i, input logic [AW-1:0] adr, input logic rdwr);
    if (i == 0) begin
      bus.c0_adr_i = adr; bus.c0_rdwr_i = rdwr;
    end else begin
      bus.c1_adr_i = adr; bus.c1_rdwr_i = rdwr;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {bus.mem_req_o, bus.mem_rdwr_o, bus.c0_ack_o, bus.c0_done_o,
                        bus.c1_ack_o, bus.c1_done_o, bus.c0_word_o, bus.c1_word_o}, 0);
    chk({tag, "_adr"}, bus.mem_adr_o, 0);
    chk({tag, "_mdat"}, bus.mem_dat_o, 0);
    chk({tag, "_cdat"}, {bus.c0_dat_o, bus.c1_dat_o}, 0);
  endtask

  // Plays memory for one granted line burst, starting from a negedge; returns at the done
  // negedge (request already dropped) or right after a planted reset.
  task automatic serve(input int g, input logic [AW-1:0] adr, input logic rdwr,
                       input int delay, input logic [DW-1:0] rdata [4], input int exp_wait0,
                       input int drop_after, input bit spur_gap, input int raise_other,
                       input int reset_at);
    logic [AW-1:0] base;
    int            waited;
    base = {adr[AW-1:4], 4'h0};
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        waited++;
      end while (!bus.mem_req_o && waited < 50);
      chk("mem_req", bus.mem_req_o, 1);
      if (!bus.mem_req_o) return;
      if (k > 0 || exp_wait0 > 0) chk("req_latency", waited, (k == 0) ? exp_wait0 : 1);
      chk("mem_adr", bus.mem_adr_o, base + 32'(4 * k));
      chk("mem_rdwr", bus.mem_rdwr_o, rdwr);
      chk("word_o", get_word(g), k);
      chk("other_word", get_word(1 - g), 0);
      if (rdwr) chk("mem_dat", bus.mem_dat_o, ((g == 1) ? 32'hA000_0000 : 32'hB000_0000) + k);
      if (k == reset_at) begin
        rst = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b1;
        set_req(g, 1'b0);
        last_served = 1;
        return;
      end
      for (int d = 0; d < delay; d++) begin
        @(negedge clk);
        chk("req_hold", bus.mem_req_o, 1);
        chk("no_early_ack", {bus.c0_ack_o, bus.c1_ack_o}, 0);
      end
      bus.mem_ack_i = 1'b1;
      bus.mem_dat_i = rdata[k];
      @(negedge clk);
      bus.mem_ack_i = spur_gap && (k < 3);
      bus.mem_dat_i = $urandom;
      chk("ack", get_ack(g), 1);
      chk("dat_o", get_dat(g), rdata[k]);
      chk("done", get_done(g), k == 3);
      chk("req_low_gap", bus.mem_req_o, 0);
      chk("other_quiet", {get_ack(1 - g), get_done(1 - g)}, 0);
      if (k == drop_after || k == 3) set_req(g, 1'b0);
      if (k == raise_other) set_req(1 - g, 1'b1);
    end
    last_served = g;
  endtask

  logic [DW-1:0] t1_data [4];
  logic [DW-1:0] rnd [4];
  int            mask;
  int            first;
  logic [AW-1:0] a0, a1;
  logic          w0, w1;

  initial begin
    bus.c0_req_i = 1'b0; bus.c0_adr_i = '0; bus.c0_rdwr_i = 1'b0;
    bus.c1_req_i = 1'b0; bus.c1_adr_i = '0; bus.c1_rdwr_i = 1'b0;
    bus.mem_ack_i = 1'b0; bus.mem_dat_i = '0;
    t1_data[0] = 32'h7533_4A52; t1_data[1] = 32'h7533_4A5E;
    t1_data[2] = 32'h7532_D252; t1_data[3] = 32'h7540_D4A5;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // c0 refill with a 3-cycle memory
    setup(0, 32'h00CC_3B40, 1'b0);
    set_req(0, 1'b1);
    serve(0, 32'h00CC_3B40, 1'b0, 3, t1_data, 1, -1, 1'b0, -1, -1);
    @(negedge clk);
    chk("idle_after_done", {bus.mem_req_o, bus.c0_ack_o, bus.c0_done_o}, 0);

    // c1 write-back
    foreach (rnd[i]) rnd[i] = $urandom;
    setup(1, 32'h0084_3B40, 1'b1);
    set_req(1, 1'b1);
    serve(1, 32'h0084_3B40, 1'b1, 1, rnd, 1, -1, 1'b0, -1, -1);

    // Simultaneous requests after reset; c0 re-raised during c1's burst
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_served = 1;
    setup(0, 32'h1234_5670, 1'b0);
    setup(1, 32'h8765_4320, 1'b1);
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    serve(0, 32'h1234_5670, 1'b0, 0, rnd, 1, -1, 1'b0, -1, -1);
    setup(0, 32'h0000_ABC0, 1'b0);
    serve(1, 32'h8765_4320, 1'b1, 2, rnd, 2, -1, 1'b0, 1, -1);
    serve(0, 32'h0000_ABC0, 1'b0, 1, rnd, 2, -1, 1'b0, -1, -1);

    // c0 drops its request after word 1; spurious acks in every gap
    @(negedge clk);
    foreach (rnd[i]) rnd[i] = $urandom;
    setup(0, 32'h00CC_3B80, 1'b0);
    set_req(0, 1'b1);
    serve(0, 32'h00CC_3B80, 1'b0, 1, rnd, 1, 1, 1'b1, -1, -1);

    // Spurious ack in IDLE
    @(negedge clk);
    bus.mem_ack_i = 1'b1;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    chk("idle_spurious", {bus.mem_req_o, bus.c0_ack_o, bus.c1_ack_o,
                          bus.c0_done_o, bus.c1_done_o}, 0);

    // Reset in XFER on word 2, then a fresh c1 burst from word 0
    setup(0, 32'h0000_5550, 1'b1);
    set_req(0, 1'b1);
    serve(0, 32'h0000_5550, 1'b1, 0, rnd, 1, -1, 1'b0, -1, 2);
    setup(1, 32'h0000_7770, 1'b0);
    set_req(1, 1'b1);
    serve(1, 32'h0000_7770, 1'b0, 1, rnd, 1, -1, 1'b0, -1, -1);

    // Randomized rounds: grant order follows round-robin over the last served requester
    for (int r = 0; r < 8; r++) begin
      mask = int'($urandom_range(1, 3));
      a0 = $urandom; a1 = $urandom;
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      foreach (rnd[i]) rnd[i] = $urandom;
      @(negedge clk);
      setup(0, a0, w0);
      setup(1, a1, w1);
      set_req(0, mask[0]);
      set_req(1, mask[1]);
      first = (mask == 3) ? 1 - last_served : ((mask == 1) ? 0 : 1);
      serve(first, (first == 1) ? a1 : a0, (first == 1) ? w1 : w0,
            int'($urandom_range(0, 3)), rnd, 1, -1, 1'b0, -1, -1);
      if (mask == 3) begin
        serve(1 - first, (first == 1) ? a0 : a1, (first == 1) ? w0 : w1,
              int'($urandom_range(0, 3)), rnd, 2, -1, 1'b0, -1, -1);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
